// File: rtl/hex_out_sequencer.sv
// hex_out_sequencer: converts a 32-bit binary value to BCD by double-dabble and
// writes the eight decimal digits to IO ports hex0..hex7 as OUT cycles.
module hex_out_sequencer #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic [4:0]  ioAddress,
    output logic [31:0] ioData,
    output logic [5:0]  ioOpcode,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;
    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n, sa;
    logic [31:0] bcd, bcd_n, sh, sh_n, adj;
    logic [2:0]  k;
    logic        ovf, ovf_n, wr, blank;

    always_comb begin
        adj = '0;
        for (int i = 0; i < 8; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Outputs are registered from next-state values so the first digit appears with WRITE entry
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bcd_n   = bcd;
        sh_n    = sh;
        ovf_n   = ovf;
        unique case (state)
            IDLE: if (start) begin
                sh_n    = value;
                bcd_n   = '0;
                cnt_n   = '0;
                ovf_n   = value > 32'd99_999_999;
                state_n = CONVERT;
            end
            CONVERT: begin
                bcd_n   = {adj[30:0], sh[31]};
                sh_n    = {sh[30:0], 1'b0};
                cnt_n   = cnt + 5'd1;
                state_n = cnt == 5'd31 ? WRITE : CONVERT;
            end
            WRITE: begin
                cnt_n   = cnt + 5'd1;
                state_n = cnt == 5'd7 ? DONE : WRITE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        wr    = state_n == WRITE;
        k     = cnt_n[2:0];
        sa    = {k, 2'b00};
        blank = ovf_n || (BLANK_LEADING && k != 3'd0 && (bcd_n >> sa) == 32'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bcd       <= '0;
            sh        <= '0;
            ovf       <= 1'b0;
            ioAddress <= '0;
            ioData    <= '0;
            ioOpcode  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bcd       <= bcd_n;
            sh        <= sh_n;
            ovf       <= ovf_n;
            ioAddress <= wr ? {2'b00, k} : 5'd0;
            ioData    <= wr ? (blank ? 32'd15 : {28'd0, bcd_n[sa +: 4]}) : 32'd0;
            ioOpcode  <= wr ? 6'b011100 : 6'b000000;
            busy      <= state_n == CONVERT || state_n == WRITE;
            done      <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_hex_out_sequencer.sv
// tb_hex_out_sequencer: directed and random values through both blanking modes,
// compared cycle by cycle against a decimal-arithmetic reference.
module tb_hex_out_sequencer;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [31:0] value = '0;
    logic [4:0]  a1, a0;
    logic [31:0] d1, d0;
    logic [5:0]  o1, o0;
    logic        b1, b0, n1, n0;
    int          tests = 0, fails = 0;

    hex_out_sequencer #(.BLANK_LEADING(1'b1)) u1 (
        .clock(clock), .reset(reset), .start(start), .value(value),
        .ioAddress(a1), .ioData(d1), .ioOpcode(o1), .busy(b1), .done(n1));
    hex_out_sequencer #(.BLANK_LEADING(1'b0)) u0 (
        .clock(clock), .reset(reset), .start(start), .value(value),
        .ioAddress(a0), .ioData(d0), .ioOpcode(o0), .busy(b0), .done(n0));

    always #5 clock = ~clock;

    // Expected decimal digit k, using plain division and the blanking rules
    function automatic logic [31:0] mdata(input logic [31:0] v, input int k, input bit bl);
        longint vv = {32'd0, v};
        longint p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (vv > 99_999_999) return 32'd15;
        if (bl && k > 0 && vv < p) return 32'd15;
        return 32'((vv / p) % 10);
    endfunction

    function automatic logic [44:0] ev(input bit b, input bit d, input logic [5:0] op,
                                       input int a, input logic [31:0] dat);
        return {b, d, op, 5'(a), dat};
    endfunction

    task automatic chk(input string tag, input logic [44:0] obs, input logic [44:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic both(input string tag, input logic [44:0] e1, input logic [44:0] e0);
        chk({tag, "/bl1"}, {b1, n1, o1, a1, d1}, e1);
        chk({tag, "/bl0"}, {b0, n0, o0, a0, d0}, e0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full request; mid = busy-cycle index for a stray start, abort_k = write index for reset
    task automatic op(input logic [31:0] v, input int mid, input int abort_k, input bit dstart);
        logic [44:0] z = '0;
        start = 1'b1;
        value = v;
        step();
        start = 1'b0;
        value = $urandom;
        for (int c = 0; c < 32; c++) begin
            both($sformatf("conv%0d", c), ev(1, 0, 0, 0, 0), ev(1, 0, 0, 0, 0));
            start = c == mid;
            if (c == mid) value = v ^ 32'h0000_5A5A;
            step();
            start = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            both($sformatf("wr%0d", k), ev(1, 0, 6'b011100, k, mdata(v, k, 1)),
                 ev(1, 0, 6'b011100, k, mdata(v, k, 0)));
            if (k == abort_k) begin
                reset = 1'b1;
                #1;
                both("async_rst", z, z);
                repeat (2) begin step(); both("in_rst", z, z); end
                reset = 1'b0;
                repeat (4) begin step(); both("post_abort", z, z); end
                return;
            end
            step();
        end
        both("done", ev(0, 1, 0, 0, 0), ev(0, 1, 0, 0, 0));
        start = dstart;
        step();
        start = 1'b0;
        both("idle", z, z);
        step();
        both("idle2", z, z);
    endtask

    initial begin
        step();
        both("reset", '0, '0);
        step();
        reset = 1'b0;
        op(32'd12345678, -1, -1, 0);
        op(32'd0, -1, -1, 0);
        op(32'd42, -1, -1, 1);
        op(32'd100_000_000, -1, -1, 0);
        op(32'hFFFF_FFFF, -1, -1, 0);
        op(32'd99_999_999, -1, -1, 0);
        op(32'd805, 9, -1, 0);
        op(32'd87654321, -1, 3, 0);
        op(32'd7, -1, -1, 0);
        repeat (3) op($urandom_range(99_999_999, 0), -1, -1, 0);
        repeat (3) op($urandom_range(9999, 0), -1, -1, 0);
        op($urandom, -1, -1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hex_out_sequencer.md
HEX_OUT_SEQUENCER -- requirements
Module: hex_out_sequencer

Interface
REQ-001 Parameter BLANK_LEADING, default 1, 1 = blank leading-zero digits, 0 = show all eight digits.
REQ-002 The block SHALL expose the following ports, all sampled on the rising edge of clock; reset is asynchronous and active-high.
REQ-003 clock  input  1  system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to display value; accepted only in IDLE.
REQ-006 value  input  32  unsigned binary number to display; captured on the accepting edge.
REQ-007 ioAddress  output  5  IO port address, 0..7 = hex0..hex7.
REQ-008 ioData  output  32  digit code for the IO port: 0..9 = digit, 15 = blank.
REQ-009 ioOpcode  output  6  6'b011100 (OUT) during write cycles, otherwise 6'b000000.
REQ-010 busy  output  1  high from the cycle after acceptance until done.
REQ-011 done  output  1  one-cycle pulse when all eight writes have been issued.

Function
REQ-012 States SHALL be IDLE, CONVERT, WRITE and DONE, with transitions IDLE->CONVERT->WRITE->DONE->IDLE.
REQ-013 In IDLE with start=1, the block SHALL capture value, clear the 32-bit BCD register and 5-bit counter, set the overflow flag if value > 99_999_999, and enter CONVERT.
REQ-014 start SHALL be ignored in every state other than IDLE; value changes after capture SHALL have no effect.
REQ-015 CONVERT SHALL last exactly 32 cycles and perform double-dabble one bit per cycle, MSB first: add 3 to each BCD nibble >= 5, then shift left with the next binary bit entering BCD bit 0.
REQ-016 WRITE SHALL last exactly 8 cycles; in cycle k (k = 0..7), ioAddress=k, ioOpcode=6'b011100, ioData={28'b0, digit k}, where digit 0 is the least significant.
REQ-017 Blanking, BLANK_LEADING=1: digit k (k>=1) SHALL be driven as 15 when digit k and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-018 Blanking, BLANK_LEADING=0: no digit SHALL be blanked except under overflow.
REQ-019 When the overflow flag is set, every WRITE cycle SHALL drive ioData=15, and the conversion result SHALL be ignored.
REQ-020 DONE SHALL last one cycle with done=1, busy=0 and ioOpcode=0, then return to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-021 busy SHALL be 1 in CONVERT and WRITE only (40 cycles).
REQ-022 Timing: with acceptance at edge E0, the first write SHALL be presented after edge E0+32, and done SHALL be high in the cycle after edge E0+40.
REQ-023 Outside WRITE, ioAddress and ioData SHALL hold 0 and ioOpcode SHALL be 6'b000000.
REQ-024 ioAddress, ioData and ioOpcode SHALL be registered outputs, with no combinational path from start or value.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, ioAddress=0, ioData=0, ioOpcode=6'b000000, busy=0, done=0, and clear the counter, BCD register and overflow flag.
REQ-026 Reset asserted mid-CONVERT or mid-WRITE SHALL abort the operation with no further OUT cycles; after release, the block SHALL accept a new start.
REQ-027 After reset is released, the first start SHALL be accepted on the first rising edge on which it is high.

Verification
REQ-028 value=12345678, start for 1 cycle -> 32 idle-opcode cycles, then addresses 0..7 carry data 8,7,6,5,4,3,2,1 with opcode 011100, then a done pulse.
REQ-029 value=0, BLANK_LEADING=1 -> address 0 data 0; addresses 1..7 data 15.
REQ-030 value=42, BLANK_LEADING=0 -> data 2,4,0,0,0,0,0,0; with BLANK_LEADING=1 -> data 2,4,15,15,15,15,15,15.
REQ-031 value=100_000_000 and value=32'hFFFFFFFF -> all eight writes carry data 15, and the done pulse still occurs.
REQ-032 Second start at the 10th busy cycle with a different value -> ignored; output matches the first value and exactly one done pulse occurs.
REQ-033 Reset asserted during the WRITE cycle with ioAddress=3 -> ioOpcode=0 and busy=0 without waiting for a clock edge; no addresses 4..7 issued; a later start with value 7 -> data 7,15,15,15,15,15,15,15.
